// File: rtl/bet_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bet_round_ctrl
// Brief    : Baccarat betting-round sequencer that owns the player balance.
// Revision : 1.0
// ============================================================================
module bet_round_ctrl #(
    parameter logic [7:0]  INIT_BALANCE   = 8'd100,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000,
    parameter logic [3:0]  TIE_MULT       = 4'd8
) (
    input  logic       slow_clock,
    input  logic       reset,
    input  logic       bet_valid,
    input  logic [1:0] bet_type,
    input  logic [7:0] bet_amount,
    input  logic       round_done,
    input  logic       dealer_win,
    input  logic       player_win,
    output logic       round_start,
    output logic       bet_ready,
    output logic       busy,
    output logic [7:0] balance,
    output logic       settle_valid,
    output logic       money_err,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_PLAY   = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    localparam logic [1:0] c_BET_PLAYER = 2'b01;
    localparam logic [1:0] c_BET_BANKER = 2'b10;
    localparam logic [1:0] c_BET_TIE    = 2'b11;

    state_t      r_state;
    logic [1:0]  r_type;
    logic [7:0]  r_amount;
    logic [15:0] r_watchdog;
    logic [7:0]  r_balance;
    logic        r_round_start;
    logic        r_settle_valid;
    logic        r_money_err;
    logic        r_timeout_err;

    logic        w_reject;
    logic        w_tie;
    logic        w_win;
    logic        w_wd_last;
    logic [11:0] w_bal12;
    logic [11:0] w_amt12;
    logic [11:0] w_tie_pay;
    logic [11:0] w_new;
    logic        w_overflow;

    assign w_reject  = (r_type == 2'b00) || (r_amount == 8'd0) || (r_amount > r_balance);
    assign w_tie     = dealer_win & player_win;
    assign w_win     = (player_win & ~dealer_win & (r_type == c_BET_PLAYER)) |
                       (dealer_win & ~player_win & (r_type == c_BET_BANKER));
    assign w_wd_last = (r_watchdog == TIMEOUT_CYCLES - 16'd1);
    assign w_bal12   = {4'd0, r_balance};
    assign w_amt12   = {4'd0, r_amount};
    assign w_tie_pay = w_amt12 * {8'd0, TIE_MULT};

    // Settlement is computed from the live result inputs so the balance lands
    // during the SETTLE cycle itself; subtraction is safe since CHECK bounded it.
    always_comb begin
        w_new = w_bal12 - w_amt12;
        if (w_tie) begin
            w_new = (r_type == c_BET_TIE) ? (w_bal12 + w_tie_pay) : w_bal12;
        end else if (w_win) begin
            w_new = w_bal12 + w_amt12;
        end
    end

    assign w_overflow = (w_new > 12'd255);

    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_type         <= 2'b00;
            r_amount       <= 8'd0;
            r_watchdog     <= 16'd0;
            r_balance      <= INIT_BALANCE;
            r_round_start  <= 1'b0;
            r_settle_valid <= 1'b0;
            r_money_err    <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_round_start  <= 1'b0;
            r_settle_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bet_valid) begin
                        r_type        <= bet_type;
                        r_amount      <= bet_amount;
                        r_money_err   <= 1'b0;
                        r_timeout_err <= 1'b0;
                        r_state       <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_reject) begin
                        r_money_err    <= 1'b1;
                        r_settle_valid <= 1'b1;
                        r_state        <= ST_IDLE;
                    end else begin
                        r_round_start <= 1'b1;
                        r_watchdog    <= 16'd0;
                        r_state       <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (round_done) begin
                        r_balance      <= w_overflow ? 8'd255 : w_new[7:0];
                        r_settle_valid <= 1'b1;
                        if (w_overflow) begin
                            r_money_err <= 1'b1;
                        end
                        r_state <= ST_SETTLE;
                    end else if (w_wd_last) begin
                        r_timeout_err  <= 1'b1;
                        r_money_err    <= 1'b1;
                        r_settle_valid <= 1'b1;
                        r_state        <= ST_IDLE;
                    end else begin
                        r_watchdog <= r_watchdog + 16'd1;
                    end
                end
                ST_SETTLE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bet_ready    = (r_state == ST_IDLE);
    assign busy         = (r_state != ST_IDLE);
    assign balance      = r_balance;
    assign round_start  = r_round_start;
    assign settle_valid = r_settle_valid;
    assign money_err    = r_money_err;
    assign timeout_err  = r_timeout_err;

endmodule
`default_nettype wire
